// File: rtl/writeback.sv
// Y86-64 writeback stage: W pipeline register, 15-entry architectural register
// file with two bypassed read ports, and sticky program status.
module writeback #(
  parameter int DATA_W = 64
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              m_valid_i,
  input  logic [2:0]        m_stat_i,
  input  logic [3:0]        m_icode_i,
  input  logic              m_cnd_i,
  input  logic [3:0]        m_dstE_i,
  input  logic [3:0]        m_dstM_i,
  input  logic [DATA_W-1:0] m_valE_i,
  input  logic [DATA_W-1:0] m_valM_i,
  input  logic              w_stall_i,
  input  logic [3:0]        srcA_i,
  input  logic [3:0]        srcB_i,
  output logic [DATA_W-1:0] valA_o,
  output logic [DATA_W-1:0] valB_o,
  output logic [3:0]        w_dstE_o,
  output logic [3:0]        w_dstM_o,
  output logic [2:0]        stat_o,
  output logic              halted_o
);

  localparam logic [3:0] REG_NONE   = 4'hF;
  localparam logic [3:0] ICODE_CMOV = 4'h2;
  localparam logic [2:0] STAT_AOK   = 3'd1;
  localparam int         NREGS      = 15;

  logic [2:0]        w_stat_q, w_stat_d;
  logic [3:0]        w_dstE_q, w_dstE_d;
  logic [3:0]        w_dstM_q, w_dstM_d;
  logic [DATA_W-1:0] w_valE_q, w_valE_d;
  logic [DATA_W-1:0] w_valM_q, w_valM_d;
  logic [2:0]        stat_q, stat_d;
  logic              halted_q, halted_d;
  logic [DATA_W-1:0] rf_q [NREGS];
  logic [DATA_W-1:0] rf_d [NREGS];

  logic              commit_en;
  logic [DATA_W-1:0] rf_a, rf_b;

  // W register: capture, bubble, or hold; frozen for good once halted.
  always_comb begin
    w_stat_d = w_stat_q;
    w_dstE_d = w_dstE_q;
    w_dstM_d = w_dstM_q;
    w_valE_d = w_valE_q;
    w_valM_d = w_valM_q;
    if (!w_stall_i && !halted_q) begin
      if (m_valid_i) begin
        w_stat_d = m_stat_i;
        w_dstE_d = (m_icode_i == ICODE_CMOV && !m_cnd_i) ? REG_NONE : m_dstE_i;
        w_dstM_d = m_dstM_i;
        w_valE_d = m_valE_i;
        w_valM_d = m_valM_i;
      end else begin
        w_stat_d = STAT_AOK;
        w_dstE_d = REG_NONE;
        w_dstM_d = REG_NONE;
        w_valE_d = '0;
        w_valM_d = '0;
      end
    end
  end

  assign commit_en = (w_stat_q == STAT_AOK) && !halted_q;

  // The M write comes last so it overrides E when both name the same register.
  always_comb begin
    rf_d = rf_q;
    if (commit_en) begin
      if (w_dstE_q != REG_NONE) rf_d[w_dstE_q] = w_valE_q;
      if (w_dstM_q != REG_NONE) rf_d[w_dstM_q] = w_valM_q;
    end
  end

  always_comb begin
    stat_d   = stat_q;
    halted_d = halted_q;
    if (!halted_q && w_stat_q != STAT_AOK) begin
      stat_d   = w_stat_q;
      halted_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      w_stat_q <= STAT_AOK;
      w_dstE_q <= REG_NONE;
      w_dstM_q <= REG_NONE;
      w_valE_q <= '0;
      w_valM_q <= '0;
      stat_q   <= STAT_AOK;
      halted_q <= 1'b0;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= DATA_W'(i);
    end else begin
      w_stat_q <= w_stat_d;
      w_dstE_q <= w_dstE_d;
      w_dstM_q <= w_dstM_d;
      w_valE_q <= w_valE_d;
      w_valM_q <= w_valM_d;
      stat_q   <= stat_d;
      halted_q <= halted_d;
      rf_q     <= rf_d;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(
    input logic [3:0]        src,
    input logic [DATA_W-1:0] rf_val,
    input logic              byp_ok,
    input logic [3:0]        dstE,
    input logic [3:0]        dstM,
    input logic [DATA_W-1:0] valE,
    input logic [DATA_W-1:0] valM
  );
    if (src == REG_NONE)             return '0;
    else if (byp_ok && src == dstM)  return valM;
    else if (byp_ok && src == dstE)  return valE;
    else                             return rf_val;
  endfunction

  assign rf_a = (srcA_i == REG_NONE) ? '0 : rf_q[srcA_i];
  assign rf_b = (srcB_i == REG_NONE) ? '0 : rf_q[srcB_i];

  assign valA_o   = read_port(srcA_i, rf_a, commit_en, w_dstE_q, w_dstM_q, w_valE_q, w_valM_q);
  assign valB_o   = read_port(srcB_i, rf_b, commit_en, w_dstE_q, w_dstM_q, w_valE_q, w_valM_q);
  assign w_dstE_o = w_dstE_q;
  assign w_dstM_o = w_dstM_q;
  assign stat_o   = stat_q;
  assign halted_o = halted_q;

endmodule

// File: tb/tb_writeback.sv
// Bench for writeback: directed scenarios plus randomized traffic compared
// against a register-file/status reference model kept in the bench.
module tb_writeback;

  localparam int DATA_W = 64;

  logic              clk_i = 1'b0;
  logic              rst_n_i = 1'b0;
  logic              m_valid_i = 1'b0;
  logic [2:0]        m_stat_i = 3'd1;
  logic [3:0]        m_icode_i = 4'h0;
  logic              m_cnd_i = 1'b0;
  logic [3:0]        m_dstE_i = 4'hF;
  logic [3:0]        m_dstM_i = 4'hF;
  logic [DATA_W-1:0] m_valE_i = '0;
  logic [DATA_W-1:0] m_valM_i = '0;
  logic              w_stall_i = 1'b0;
  logic [3:0]        srcA_i = 4'hF;
  logic [3:0]        srcB_i = 4'hF;
  logic [DATA_W-1:0] valA_o, valB_o;
  logic [3:0]        w_dstE_o, w_dstM_o;
  logic [2:0]        stat_o;
  logic              halted_o;

  writeback #(.DATA_W(DATA_W)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .m_valid_i(m_valid_i), .m_stat_i(m_stat_i), .m_icode_i(m_icode_i),
    .m_cnd_i(m_cnd_i), .m_dstE_i(m_dstE_i), .m_dstM_i(m_dstM_i),
    .m_valE_i(m_valE_i), .m_valM_i(m_valM_i), .w_stall_i(w_stall_i),
    .srcA_i(srcA_i), .srcB_i(srcB_i), .valA_o(valA_o), .valB_o(valB_o),
    .w_dstE_o(w_dstE_o), .w_dstM_o(w_dstM_o), .stat_o(stat_o), .halted_o(halted_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: architectural registers, the instruction waiting in W, status.
  logic [63:0] ref_rf [15];
  logic [2:0]  r_wstat;
  logic [3:0]  r_dstE, r_dstM;
  logic [63:0] r_valE, r_valM;
  logic [2:0]  r_stat;
  logic        r_halted;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 15; i++) ref_rf[i] = 64'(i);
    r_wstat = 3'd1; r_dstE = 4'hF; r_dstM = 4'hF; r_valE = '0; r_valM = '0;
    r_stat = 3'd1; r_halted = 1'b0;
  endtask

  function automatic logic [63:0] exp_read(input logic [3:0] src);
    logic live;
    live = (r_wstat == 3'd1) && !r_halted;
    if (src == 4'hF) return 64'd0;
    if (live && src == r_dstM) return r_valM;
    if (live && src == r_dstE) return r_valE;
    return ref_rf[src];
  endfunction

  // Effect of one rising edge, computed from the state before the edge.
  task automatic model_edge();
    logic was_halted;
    was_halted = r_halted;
    if (r_wstat == 3'd1 && !was_halted) begin
      if (r_dstE != 4'hF) ref_rf[r_dstE] = r_valE;
      if (r_dstM != 4'hF) ref_rf[r_dstM] = r_valM;
    end
    if (!was_halted && r_wstat != 3'd1) begin
      r_stat = r_wstat;
      r_halted = 1'b1;
    end
    if (!w_stall_i && !was_halted) begin
      if (m_valid_i) begin
        r_wstat = m_stat_i;
        r_dstE = (m_icode_i == 4'h2 && !m_cnd_i) ? 4'hF : m_dstE_i;
        r_dstM = m_dstM_i;
        r_valE = m_valE_i;
        r_valM = m_valM_i;
      end else begin
        r_wstat = 3'd1; r_dstE = 4'hF; r_dstM = 4'hF; r_valE = '0; r_valM = '0;
      end
    end
  endtask

  task automatic check_all();
    check("valA", valA_o, exp_read(srcA_i));
    check("valB", valB_o, exp_read(srcB_i));
    check("w_dstE", 64'(w_dstE_o), 64'(r_dstE));
    check("w_dstM", 64'(w_dstM_o), 64'(r_dstM));
    check("stat", 64'(stat_o), 64'(r_stat));
    check("halted", 64'(halted_o), 64'(r_halted));
  endtask

  // Inputs are already set (shortly after a rising edge); check at the falling
  // edge, then advance the model across the next rising edge.
  task automatic cycle();
    @(negedge clk_i);
    check_all();
    @(posedge clk_i);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic vld, input logic [2:0] st, input logic [3:0] ic,
                       input logic cnd, input logic [3:0] de, input logic [3:0] dm,
                       input logic [63:0] ve, input logic [63:0] vm);
    m_valid_i = vld; m_stat_i = st; m_icode_i = ic; m_cnd_i = cnd;
    m_dstE_i = de; m_dstM_i = dm; m_valE_i = ve; m_valM_i = vm;
  endtask

  task automatic idle();
    drive(1'b0, 3'd1, 4'h0, 1'b0, 4'hF, 4'hF, 64'd0, 64'd0);
  endtask

  // Reset pulse placed between clock edges.
  task automatic do_reset();
    rst_n_i = 1'b0;
    model_reset();
    #3;
    rst_n_i = 1'b1;
  endtask

  initial begin
    int halt_cycles;
    model_reset();
    idle();
    @(posedge clk_i); #1;
    do_reset();

    // Reset values.
    srcA_i = 4'd3; srcB_i = 4'hF;
    #1;
    check("rst_valA3", valA_o, 64'd3);
    check("rst_valBF", valB_o, 64'd0);
    check("rst_stat", 64'(stat_o), 64'd1);
    check("rst_halted", 64'(halted_o), 64'd0);
    check("rst_dstE", 64'(w_dstE_o), 64'hF);
    cycle();

    // irmovq to %rdx: bypass, then committed.
    srcB_i = 4'd2;
    drive(1'b1, 3'd1, 4'h3, 1'b1, 4'd2, 4'hF, 64'h55, 64'd0);
    cycle();
    check("irmov_byp", valB_o, 64'h55);
    idle();
    cycle();
    check("irmov_rf", valB_o, 64'h55);
    check("irmov_bubble", 64'(w_dstE_o), 64'hF);

    // cmov not taken, then taken.
    srcA_i = 4'd5;
    drive(1'b1, 3'd1, 4'h2, 1'b0, 4'd5, 4'hF, 64'hAA, 64'd0);
    cycle();
    check("cmov_nt_dst", 64'(w_dstE_o), 64'hF);
    idle(); cycle();
    check("cmov_nt_rf", valA_o, 64'd5);
    drive(1'b1, 3'd1, 4'h2, 1'b1, 4'd5, 4'hF, 64'hAA, 64'd0);
    cycle();
    check("cmov_t_dst", 64'(w_dstE_o), 64'd5);
    idle(); cycle();
    check("cmov_t_rf", valA_o, 64'hAA);

    // popq %rsp: valM wins.
    srcA_i = 4'd4;
    drive(1'b1, 3'd1, 4'hB, 1'b1, 4'd4, 4'd4, 64'h100, 64'h200);
    cycle();
    check("popq_byp", valA_o, 64'h200);
    idle(); cycle();
    check("popq_rf", valA_o, 64'h200);

    // Bypass priority M over E on the same register.
    srcA_i = 4'd7;
    drive(1'b1, 3'd1, 4'h5, 1'b1, 4'd7, 4'd7, 64'd1, 64'd2);
    cycle();
    check("byp_prio", valA_o, 64'd2);
    idle(); cycle();

    // Stall holds W and the repeated commit is harmless.
    srcA_i = 4'd8;
    drive(1'b1, 3'd1, 4'h3, 1'b1, 4'd8, 4'hF, 64'h88, 64'd0);
    cycle();
    w_stall_i = 1'b1;
    drive(1'b1, 3'd1, 4'h3, 1'b1, 4'd9, 4'hF, 64'h99, 64'd0);
    cycle(); cycle();
    check("stall_hold", 64'(w_dstE_o), 64'd8);
    w_stall_i = 1'b0;
    idle(); cycle(); cycle();

    // Halt: faulting instruction writes nothing; later input ignored.
    srcA_i = 4'd1;
    drive(1'b1, 3'd2, 4'h0, 1'b1, 4'd1, 4'hF, 64'h99, 64'd0);
    cycle();
    check("halt_pre", 64'(halted_o), 64'd0);
    drive(1'b1, 3'd1, 4'h3, 1'b1, 4'd1, 4'hF, 64'h77, 64'd0);
    cycle();
    check("halt_set", 64'(halted_o), 64'd1);
    check("halt_stat", 64'(stat_o), 64'd2);
    for (int i = 0; i < 4; i++) cycle();
    check("halt_rf", valA_o, 64'd1);

    // Reset with a write pending in W.
    do_reset();
    srcA_i = 4'd6;
    drive(1'b1, 3'd1, 4'h3, 1'b1, 4'd6, 4'hF, 64'h66, 64'd0);
    cycle();
    do_reset();
    idle();
    cycle();
    check("rst_pending", valA_o, 64'd6);
    check("rst_stat2", 64'(stat_o), 64'd1);

    // Randomized traffic.
    halt_cycles = 0;
    for (int n = 0; n < 600; n++) begin
      logic [2:0] st;
      st = ($urandom_range(0, 40) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
      drive(($urandom_range(0, 3) != 0), st, 4'($urandom_range(0, 11)),
            1'($urandom), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hF,
            {$urandom, $urandom}, {$urandom, $urandom});
      w_stall_i = ($urandom_range(0, 4) == 0);
      srcA_i = 4'($urandom_range(0, 15));
      srcB_i = 4'($urandom_range(0, 15));
      cycle();
      if (r_halted) halt_cycles++;
      if (halt_cycles > 3 || $urandom_range(0, 150) == 0) begin
        halt_cycles = 0;
        do_reset();
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/writeback.md
# writeback

Y86-64 pipeline writeback stage and owner of the architectural register file. It holds the W pipeline register and commits `valE`/`valM` results to `%rax`–`%r14` on the write side. It serves two bypassed combinational read ports to the decode side and tracks sticky program status (halt/fault). It sits between the memory stage (producer of `m_*`) and the decode stage, which consumes `valA_o`/`valB_o` and `w_dst*_o`.

## Interface
- `DATA_W`, 64, register/data width
- `clk_i`  in  1  clock, rising edge
- `rst_n_i`  in  1  reset, asynchronous, active-low
- `m_valid_i`  in  1  memory stage presents an instruction this cycle
- `m_stat_i`  in  3  status: 1=AOK, 2=HLT, 3=ADR, 4=INS
- `m_icode_i`  in  4  instruction code
- `m_cnd_i`  in  1  condition result; used for cmovXX (icode 2)
- `m_dstE_i`  in  4  E destination, F=none
- `m_dstM_i`  in  4  M destination, F=none
- `m_valE_i`  in  DATA_W  ALU result
- `m_valM_i`  in  DATA_W  memory read data
- `w_stall_i`  in  1  hold W register
- `srcA_i`, `srcB_i`  in  4  decode read addresses
- `valA_o`, `valB_o`  out  DATA_W  read data (bypassed)
- `w_dstE_o`, `w_dstM_o`  out  4  W-register destinations, for hazard logic
- `stat_o`  out  3  program status
- `halted_o`  out  1  sticky stop indication

## Operation
- Register file: 15 × DATA_W entries, index 0–14. Register F is not stored.
- W register load, each rising edge when `w_stall_i`=0 and `halted_o`=0:
  - `m_valid_i`=1: capture `m_*`.
  - `m_valid_i`=0: load a bubble (icode 0, stat AOK, dstE=dstM=F, vals 0).
- cmov squash at capture: if `m_icode_i`=2 and `m_cnd_i`=0, store dstE=F.
- Commit, each rising edge, from current W contents, when W stat=AOK and `halted_o`=0:
  - `regfile[W_dstE] <= W_valE` if dstE≠F.
  - `regfile[W_dstM] <= W_valM` if dstM≠F.
  - dstE=dstM (popq `%rsp`): valM wins; exactly one write.
- Stall: W holds its contents. The commit repeats with identical data, which is idempotent.
- Status:
  - W stat≠AOK: `stat_o` takes W stat at the next edge and `halted_o` sets.
  - Both are sticky until reset.
  - Once halted, the W register freezes and all commits are blocked, including the faulting instruction's own writes.
  - A bubble in W never changes `stat_o`.
- Read port per src, priority order:
  1. src=F → 0.
  2. src=W_dstM and W stat=AOK and not halted → W_valM.
  3. src=W_dstE under the same conditions → W_valE.
  4. Otherwise → `regfile[src]`.
- Outputs `w_dstE_o`/`w_dstM_o` = W register fields (after cmov squash).

## Timing
- Reset (async assert, sync-safe deassert):
  - `regfile[i]`=i for i=0..14.
  - W = bubble.
  - `stat_o`=1 (AOK), `halted_o`=0.
  - `valA_o`/`valB_o` = `regfile[src]` or 0; `w_dst*_o`=F.
- Latency:
  - `m_*` captured at edge N.
  - Visible on read ports via bypass during cycle N→N+1.
  - Written to regfile at edge N+1; visible unbypassed thereafter.
- Reset asserted mid-operation: pending W commit is discarded; all state returns to reset values immediately.
- Read ports are purely combinational from `src*_i`, W and regfile. There is no read latency.
- Fault in W at edge N: `halted_o`=1 after edge N+1. No regfile write at N+1 or later.

## Test plan
- Reset values: assert `rst_n_i` low mid-cycle, then release → `valA_o` for src 3 = 3, for src F = 0; `stat_o`=1, `halted_o`=0.
- irmovq path: m dstE=2, valE=0x55, valid, at edge N → `valB_o`(src 2)=0x55 in the next cycle via bypass; `regfile[2]`=0x55 after edge N+1 with W then a bubble.
- cmov not taken: icode 2, cnd=0, dstE=5, valE=0xAA → `w_dstE_o`=F; `regfile[5]` stays 5. Repeat with cnd=1 → 0xAA.
- popq `%rsp`: dstE=dstM=4, valE=0x100, valM=0x200 → bypass and final `regfile[4]`=0x200.
- Bypass priority: W dstE=7 valE=1 and dstM=7 valM=2 → `valA_o`(src 7)=2.
- Halt: W stat=2 with dstE=1 valE=0x99 → `halted_o`=1 and `stat_o`=2 after the next edge; `regfile[1]` stays 1. Later valid AOK inputs are ignored until reset.
